// File: rtl/seq_pattern_fsm_pkg.sv
//------------------------------------------------------------------------------
// seq_pattern_fsm_pkg
// Shared types and helpers for the programmable sequence detector.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_pattern_fsm_pkg;

    // Table fields are stored at this fixed width; narrower inputs are zero-extended.
    localparam int SEQ_IN_MAX = 16;
    localparam int STEP_IDLE  = 0;

    typedef enum logic [0:0] {
        SEQ_RUN  = 1'b0,
        SEQ_DONE = 1'b1
    } seq_mode_e;

    typedef struct packed {
        logic [SEQ_IN_MAX-1:0] adv_mask;
        logic [SEQ_IN_MAX-1:0] adv_val;
        logic [SEQ_IN_MAX-1:0] hold_mask;
        logic [SEQ_IN_MAX-1:0] hold_val;
    } seq_entry_t;

    function automatic logic mask_hit(
        input logic [SEQ_IN_MAX-1:0] in_bits,
        input logic [SEQ_IN_MAX-1:0] mask,
        input logic [SEQ_IN_MAX-1:0] val
    );
        return ((in_bits & mask) == val);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_pattern_fsm_step_table.sv
//------------------------------------------------------------------------------
// seq_step_table
// Step table with one write port and a combinational compare at the read index.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_step_table
    import seq_pattern_fsm_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int NUM_STEPS = 12,
    parameter int STEP_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [STEP_W-1:0] addr_i,
    input  logic [NUM_IN-1:0] adv_mask_i,
    input  logic [NUM_IN-1:0] adv_val_i,
    input  logic [NUM_IN-1:0] hold_mask_i,
    input  logic [NUM_IN-1:0] hold_val_i,
    input  logic [STEP_W-1:0] rd_idx_i,
    input  logic [NUM_IN-1:0] in_vec_i,
    output logic              adv_hit_o,
    output logic              hold_hit_o
);

    seq_entry_t wr_entry;
    seq_entry_t sel_entry;
    seq_entry_t entries [NUM_STEPS];
    logic [SEQ_IN_MAX-1:0] in_ext;

    assign wr_entry.adv_mask  = SEQ_IN_MAX'(adv_mask_i);
    assign wr_entry.adv_val   = SEQ_IN_MAX'(adv_val_i);
    assign wr_entry.hold_mask = SEQ_IN_MAX'(hold_mask_i);
    assign wr_entry.hold_val  = SEQ_IN_MAX'(hold_val_i);
    assign in_ext             = SEQ_IN_MAX'(in_vec_i);

    // Only indices below NUM_STEPS have storage, so larger addresses fall through.
    for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_entry
        seq_entry_t entry_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                entry_q <= '0;
            end else if (we_i && (addr_i == STEP_W'(gi))) begin
                entry_q <= wr_entry;
            end
        end

        assign entries[gi] = entry_q;
    end

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (rd_idx_i == STEP_W'(i)) begin
                sel_entry = entries[i];
            end
        end
    end

    assign adv_hit_o  = mask_hit(in_ext, sel_entry.adv_mask,  sel_entry.adv_val);
    assign hold_hit_o = mask_hit(in_ext, sel_entry.hold_mask, sel_entry.hold_val);

endmodule

`default_nettype wire

// File: rtl/seq_pattern_fsm.sv
//------------------------------------------------------------------------------
// seq_pattern_fsm
// Programmable input-sequence detector with hold timeout and one-shot/re-arm.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_pattern_fsm
    import seq_pattern_fsm_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int NUM_STEPS = 12,
    parameter int STEP_W    = 4,
    parameter int TMO_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] in_vec,
    input  logic              cfg_we,
    input  logic [STEP_W-1:0] cfg_addr,
    input  logic [NUM_IN-1:0] cfg_adv_mask,
    input  logic [NUM_IN-1:0] cfg_adv_val,
    input  logic [NUM_IN-1:0] cfg_hold_mask,
    input  logic [NUM_IN-1:0] cfg_hold_val,
    input  logic [TMO_W-1:0]  hold_limit,
    input  logic              rearm,
    input  logic              clear_done,
    output logic [STEP_W-1:0] step,
    output logic              active,
    output logic              match,
    output logic              fail,
    output logic              done
);

    localparam logic [STEP_W-1:0] C_STEP_IDLE = STEP_W'(STEP_IDLE);
    localparam logic [STEP_W-1:0] C_STEP_LAST = STEP_W'(NUM_STEPS - 1);
    localparam logic [TMO_W-1:0]  C_CNT_MAX   = {TMO_W{1'b1}};

    logic [STEP_W-1:0] step_q, step_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    seq_mode_e         mode_q, mode_d;
    logic              match_q, match_d;
    logic              fail_q, fail_d;
    logic              active_q, active_d;
    logic              adv_hit;
    logic              hold_hit;

    seq_step_table #(
        .NUM_IN    (NUM_IN),
        .NUM_STEPS (NUM_STEPS),
        .STEP_W    (STEP_W)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .we_i        (cfg_we),
        .addr_i      (cfg_addr),
        .adv_mask_i  (cfg_adv_mask),
        .adv_val_i   (cfg_adv_val),
        .hold_mask_i (cfg_hold_mask),
        .hold_val_i  (cfg_hold_val),
        .rd_idx_i    (step_q),
        .in_vec_i    (in_vec),
        .adv_hit_o   (adv_hit),
        .hold_hit_o  (hold_hit)
    );

    always_comb begin
        step_d  = step_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        match_d = 1'b0;
        fail_d  = 1'b0;

        if (cfg_we) begin
            // A table write restarts the walk; the sticky done flag is left alone.
            step_d = C_STEP_IDLE;
            cnt_d  = '0;
        end else if (mode_q == SEQ_DONE) begin
            if (clear_done) begin
                mode_d = SEQ_RUN;
                step_d = C_STEP_IDLE;
                cnt_d  = '0;
            end
        end else if (adv_hit) begin
            cnt_d = '0;
            if (step_q == C_STEP_LAST) begin
                match_d = 1'b1;
                if (rearm) begin
                    step_d = C_STEP_IDLE;
                end else begin
                    mode_d = SEQ_DONE;
                end
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end else if (hold_hit && !((hold_limit != '0) && (cnt_q == hold_limit))) begin
            if (cnt_q != C_CNT_MAX) begin
                cnt_d = cnt_q + TMO_W'(1);
            end
        end else begin
            step_d = C_STEP_IDLE;
            cnt_d  = '0;
            fail_d = (step_q != C_STEP_IDLE);
        end

        active_d = (step_d != C_STEP_IDLE) && (mode_d != SEQ_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q   <= C_STEP_IDLE;
            cnt_q    <= '0;
            mode_q   <= SEQ_RUN;
            match_q  <= 1'b0;
            fail_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            match_q  <= match_d;
            fail_q   <= fail_d;
            active_q <= active_d;
        end
    end

    assign step   = step_q;
    assign active = active_q;
    assign match  = match_q;
    assign fail   = fail_q;
    assign done   = (mode_q == SEQ_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_fsm.sv
//------------------------------------------------------------------------------
// tb_seq_pattern_fsm
// Directed and randomized checks of seq_pattern_fsm against a reference model.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_pattern_fsm;

    localparam int NS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_vec;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [3:0] cfg_adv_mask, cfg_adv_val, cfg_hold_mask, cfg_hold_val;
    logic [7:0] hold_limit;
    logic       rearm;
    logic       clear_done;
    logic [3:0] step;
    logic       active, match, fail, done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int t_am[NS], t_av[NS], t_hm[NS], t_hv[NS];
    int m_step, m_cnt;
    bit m_done, m_match, m_fail;

    seq_pattern_fsm #(
        .NUM_IN    (4),
        .NUM_STEPS (NS),
        .STEP_W    (4),
        .TMO_W     (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_vec        (in_vec),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_adv_mask  (cfg_adv_mask),
        .cfg_adv_val   (cfg_adv_val),
        .cfg_hold_mask (cfg_hold_mask),
        .cfg_hold_val  (cfg_hold_val),
        .hold_limit    (hold_limit),
        .rearm         (rearm),
        .clear_done    (clear_done),
        .step          (step),
        .active        (active),
        .match         (match),
        .fail          (fail),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies the detector rules to the inputs presented at this edge.
    task automatic model_edge();
        bit a_hit, h_hit, timed_out;
        int iv;
        m_match = 0;
        m_fail  = 0;
        iv = int'(in_vec);
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                t_am[i] = 0; t_av[i] = 0; t_hm[i] = 0; t_hv[i] = 0;
            end
            m_step = 0; m_cnt = 0; m_done = 0;
        end else if (cfg_we) begin
            if (int'(cfg_addr) < NS) begin
                t_am[cfg_addr] = int'(cfg_adv_mask);
                t_av[cfg_addr] = int'(cfg_adv_val);
                t_hm[cfg_addr] = int'(cfg_hold_mask);
                t_hv[cfg_addr] = int'(cfg_hold_val);
            end
            m_step = 0; m_cnt = 0;
        end else if (m_done) begin
            if (clear_done) begin
                m_done = 0; m_step = 0; m_cnt = 0;
            end
        end else begin
            a_hit = ((iv & t_am[m_step]) == t_av[m_step]);
            h_hit = ((iv & t_hm[m_step]) == t_hv[m_step]);
            timed_out = (hold_limit != 0) && (m_cnt == int'(hold_limit));
            if (a_hit) begin
                m_cnt = 0;
                if (m_step == NS - 1) begin
                    m_match = 1;
                    if (rearm) m_step = 0;
                    else       m_done = 1;
                end else begin
                    m_step = m_step + 1;
                end
            end else if (h_hit && !timed_out) begin
                m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            end else begin
                m_fail = (m_step > 0);
                m_step = 0;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("step",   32'(step),   32'(m_step));
        chk("active", 32'(active), 32'((m_step != 0) && !m_done));
        chk("match",  32'(match),  32'(m_match));
        chk("fail",   32'(fail),   32'(m_fail));
        chk("done",   32'(done),   32'(m_done));
    endtask

    task automatic wr(input int a, input int am, input int av, input int hm, input int hv);
        cfg_we        = 1'b1;
        cfg_addr      = 4'(a);
        cfg_adv_mask  = 4'(am);
        cfg_adv_val   = 4'(av);
        cfg_hold_mask = 4'(hm);
        cfg_hold_val  = 4'(hv);
        tick();
        cfg_we        = 1'b0;
    endtask

    task automatic program_std();
        in_vec = 4'b0000;
        wr(0, 4'b0100, 4'b0100, 4'b1111, 4'b1111);
        wr(1, 4'b1001, 4'b1001, 4'b0100, 4'b0100);
        wr(2, 4'b0100, 4'b0000, 4'b1001, 4'b1001);
    endtask

    task automatic drive(input logic [3:0] v);
        in_vec = v;
        tick();
    endtask

    initial begin
        reset = 1'b1; in_vec = '0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_adv_mask = '0; cfg_adv_val = '0; cfg_hold_mask = '0; cfg_hold_val = '0;
        hold_limit = '0; rearm = 1'b0; clear_done = 1'b0;
        m_step = 0; m_cnt = 0; m_done = 0; m_match = 0; m_fail = 0;
        for (int i = 0; i < NS; i++) begin
            t_am[i] = 0; t_av[i] = 0; t_hm[i] = 0; t_hv[i] = 0;
        end

        tick();
        tick();
        chk("rst_step", 32'(step), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b0;

        // One-shot match
        program_std();
        drive(4'b0100); chk("os_step1", 32'(step), 1);
        drive(4'b1001); chk("os_step2", 32'(step), 2);
        drive(4'b0000); chk("os_match", 32'(match), 1);
        chk("os_done", 32'(done), 1);
        drive(4'b0100); chk("os_hold_step", 32'(step), 2);
        chk("os_match_once", 32'(match), 0);
        drive(4'b1001);

        // Clear and restart
        clear_done = 1'b1; tick(); clear_done = 1'b0;
        chk("clr_done", 32'(done), 0);
        drive(4'b0100); drive(4'b1001); drive(4'b0000);
        chk("clr_rematch", 32'(match), 1);
        clear_done = 1'b1; tick(); clear_done = 1'b0;

        // clear_done outside DONE is ignored
        drive(4'b0100);
        clear_done = 1'b1; drive(4'b0100); clear_done = 1'b0;
        chk("clr_ignored", 32'(step), 1);

        // Hold then fail
        for (int i = 0; i < 5; i++) drive(4'b0100);
        chk("hold_step", 32'(step), 1);
        drive(4'b0000); chk("hold_fail", 32'(fail), 1);
        drive(4'b0000); chk("hold_fail_pulse", 32'(fail), 0);

        // Timeout: fourth hold cycle times out
        hold_limit = 8'd3;
        drive(4'b0100);
        for (int i = 0; i < 3; i++) drive(4'b0100);
        chk("tmo_wait", 32'(step), 1);
        drive(4'b0100); chk("tmo_fail", 32'(fail), 1);
        drive(4'b0100); drive(4'b0100); drive(4'b0100); drive(4'b0100);
        chk("tmo_cnt_reset", 32'(step), 1);
        drive(4'b0000);

        // Counter saturates with unlimited hold
        hold_limit = 8'd0;
        drive(4'b0100);
        for (int i = 0; i < 300; i++) drive(4'b0100);
        hold_limit = 8'd255;
        drive(4'b0100); chk("sat_fail", 32'(fail), 1);
        hold_limit = 8'd0;

        // Re-arm: two back-to-back matches
        rearm = 1'b1;
        drive(4'b0100); drive(4'b1001); drive(4'b0000);
        chk("ra_match1", 32'(match), 1);
        chk("ra_step0", 32'(step), 0);
        drive(4'b0100); drive(4'b1001); drive(4'b0000);
        chk("ra_match2", 32'(match), 1);
        chk("ra_done", 32'(done), 0);
        rearm = 1'b0;

        // Abort by reset at step 2
        drive(4'b0100); drive(4'b1001);
        reset = 1'b1; drive(4'b0000); reset = 1'b0;
        chk("ab_rst_step", 32'(step), 0);
        chk("ab_rst_fail", 32'(fail), 0);

        // Abort by cfg_we at step 2, then new entry 0 drives behaviour
        program_std();
        drive(4'b0100); drive(4'b1001);
        wr(0, 4'b0010, 4'b0010, 4'b1111, 4'b1111);
        chk("ab_we_step", 32'(step), 0);
        chk("ab_we_fail", 32'(fail), 0);
        drive(4'b0100); chk("ab_new_idle", 32'(step), 0);
        drive(4'b0010); chk("ab_new_adv", 32'(step), 1);
        wr(7, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        drive(4'b0010); chk("oor_ignored", 32'(step), 1);

        // Randomized phase
        for (int i = 0; i < NS; i++) begin
            int am, hm;
            am = $urandom_range(0, 15);
            hm = $urandom_range(0, 15);
            wr(i, am, $urandom_range(0, 15) & am, hm, $urandom_range(0, 15) & hm);
        end
        for (int c = 0; c < 800; c++) begin
            int am, hm;
            reset      = ($urandom_range(0, 199) == 0);
            cfg_we     = ($urandom_range(0, 49) == 0);
            cfg_addr   = 4'($urandom_range(0, 5));
            am         = $urandom_range(0, 15);
            hm         = $urandom_range(0, 15);
            cfg_adv_mask  = 4'(am);
            cfg_adv_val   = 4'($urandom_range(0, 15) & am);
            cfg_hold_mask = 4'(hm);
            cfg_hold_val  = 4'($urandom_range(0, 15) & hm);
            in_vec     = 4'($urandom_range(0, 15));
            hold_limit = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) rearm = ~rearm;
            clear_done = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
